aes_inv_key_expand: RTL and testbench
=====================================

AES_INV_KEY_EXPAND -- requirements
Module: aes_inv_key_expand

Interface
- REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only 10 is supported.
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port kld, input, 1 bit: load cipher key and start expansion.
- REQ-005 SHALL have port key, input, 128 bits: cipher key; key[127:96] is w0 and key[31:0] is w3.
- REQ-006 SHALL have port next, input, 1 bit: step to the previous round key.
- REQ-007 SHALL have port rewind, input, 1 bit: restore the cached round-10 key.
- REQ-008 SHALL have ports rkey0, rkey1, rkey2, rkey3, output, 32 bits each: current round key words w0..w3.
- REQ-009 SHALL have port rnd, output, 4 bits: round index of the presented key (0..10).
- REQ-010 SHALL have port busy, output, 1 bit: forward expansion in progress.
- REQ-011 SHALL have port ready, output, 1 bit: rkey0..3 hold a valid round key for round rnd.

Function
- REQ-012 SHALL implement state machine IDLE, FWD and RDY, encoded in registers.
- REQ-013 SHALL, in any state, on kld=1 at an edge: load w0..w3 from key, set rnd=0, enter FWD, set busy=1 and ready=0; kld has top priority over next and rewind.
- REQ-014 SHALL, in FWD, at each edge with kld=0, apply one forward step: t=SubWord(RotWord(w3))^{rcon(rnd+1),24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; rnd increments.
- REQ-015 SHALL leave FWD for RDY at the edge where rnd becomes 10, with busy=0 and ready=1; ready therefore rises exactly 10 cycles after the kld edge.
- REQ-016 SHALL, at that same edge, copy the round-10 key into a 128-bit cache register.
- REQ-017 SHALL, in RDY, on next=1 with rnd>0, apply one inverse step at the edge: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{rcon(rnd),24'h0}; rnd decrements.
- REQ-018 SHALL treat next=1 at rnd=0 as a no-op: state, keys and rnd unchanged, ready stays 1.
- REQ-019 SHALL, in RDY, on rewind=1, load w0..w3 from the cache and set rnd=10 in one cycle; rewind has priority over next.
- REQ-020 SHALL ignore next and rewind in IDLE and FWD.
- REQ-021 SHALL use rcon(r) for r=1..10 as 01,02,04,08,10,20,40,80,1b,36 (hex); other indices give 00.
- REQ-022 SHALL use one shared bank of four byte S-box instances, with the input muxed between w3 (FWD) and w3^w2 (RDY inverse step).
- REQ-023 SHALL, in RDY with no command, hold rkey0..3 and rnd stable.
- REQ-024 SHALL keep all outputs registered; no combinational path from inputs to outputs.

Reset
- REQ-025 SHALL, while rst=1, immediately force state IDLE, w0..w3=0, cache=0, rnd=0, busy=0 and ready=0, including in the middle of FWD or RDY.
- REQ-026 SHALL, after rst is released, stay in IDLE until kld=1; a prior expansion is not resumed.

Verification
- REQ-027 SHALL check: kld with key 2b7e151628aed2a6abf7158809cf4f3c -> 10 cycles later ready=1, rnd=10, rkey0..3 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- REQ-028 SHALL check: one next pulse from that state -> rnd=9, rkey0..3 = ac7766f3 19fadc21 28d12941 575c006e; ten total pulses -> rnd=0 and rkey0..3 = the original key.
- REQ-029 SHALL check: an eleventh next at rnd=0 -> no change; rewind then gives rnd=10 and the round-10 key one cycle later.
- REQ-030 SHALL check: kld asserted at FWD cycle 5 with a new key -> expansion restarts, and ready rises 10 cycles after the second kld with that key's round-10 key.
- REQ-031 SHALL check: rst pulsed mid-FWD and mid-RDY -> all outputs 0 asynchronously; next and rewind after reset have no effect.
- REQ-032 SHALL check: next and rewind asserted together at rnd=4 -> rnd=10 (rewind wins); kld with next asserted -> rnd=0 and busy=1.

Source files
------------

// File: rtl/aes_inv_key_expand.sv
// aes_inv_key_expand: AES-128 key schedule that expands forward to round 10, then steps back one round key per request.
// Ports: clk/rst (async active-high), kld+key load a cipher key and start the forward expansion,
// next steps to the previous round key, rewind restores the cached round-10 key,
// rkey0..3 hold the current round key words w0..w3, rnd is its round index,
// busy is high during the forward expansion, ready is high when rkey0..3 are valid for round rnd.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] sq, iv;
  // GF(2^8) inverse as a^254 (the product of a^2, a^4 ... a^128), then the AES affine map
  always_comb begin
    sq = a_i;
    iv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      iv = gmul(iv, sq);
    end
    s_o = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         next,
  input  logic         rewind,
  output logic [31:0]  rkey0,
  output logic [31:0]  rkey1,
  output logic [31:0]  rkey2,
  output logic [31:0]  rkey3,
  output logic [3:0]   rnd,
  output logic         busy,
  output logic         ready
);
  typedef enum logic [1:0] {IDLE, FWD, RDY} state_t;
  state_t state_q, state_d;
  logic [127:0] w_q, w_d, cache_q, cache_d, fwd_w, inv_w;
  logic [3:0] rnd_q, rnd_d;
  logic busy_q, busy_d, ready_q, ready_d;
  logic [31:0] w0, w1, w2, w3, sb_in, rot, sub, t, f0, f1, f2;
  logic [7:0] rc;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  assign {w0, w1, w2, w3} = w_q;
  // one S-box bank serves both directions: the inverse step needs the recovered w3 (= w3^w2)
  assign sb_in = state_q == RDY ? w3 ^ w2 : w3;
  assign rot = {sb_in[23:0], sb_in[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*i +: 8]), .s_o(sub[8*i +: 8]));
  end
  // forward uses rcon of the round being produced, inverse uses rcon of the round being undone
  assign rc = rcon(state_q == FWD ? rnd_q + 4'd1 : rnd_q);
  assign t = sub ^ {rc, 24'h0};
  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign fwd_w = {f0, f1, f2, w3 ^ f2};
  assign inv_w = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    cache_d = cache_q;
    rnd_d = rnd_q;
    busy_d = busy_q;
    ready_d = ready_q;
    if (kld) begin
      state_d = FWD;
      w_d = key;
      rnd_d = '0;
      busy_d = 1'b1;
      ready_d = 1'b0;
    end else if (state_q == FWD) begin
      w_d = fwd_w;
      rnd_d = rnd_q + 4'd1;
      if (rnd_q == 4'(NR - 1)) begin
        state_d = RDY;
        cache_d = fwd_w;
        busy_d = 1'b0;
        ready_d = 1'b1;
      end
    end else if (state_q == RDY) begin
      if (rewind) begin
        w_d = cache_q;
        rnd_d = 4'(NR);
      end else if (next && rnd_q != 4'd0) begin
        w_d = inv_w;
        rnd_d = rnd_q - 4'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q <= '0;
      cache_q <= '0;
      rnd_q <= '0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      cache_q <= cache_d;
      rnd_q <= rnd_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
    end
  end
  assign {rkey0, rkey1, rkey2, rkey3} = w_q;
  assign rnd = rnd_q;
  assign busy = busy_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// tb_aes_inv_key_expand: directed scoreboard bench for aes_inv_key_expand.
module tb_aes_inv_key_expand;
  logic clk = 1'b0, rst = 1'b1, kld = 1'b0, next = 1'b0, rewind = 1'b0;
  logic [127:0] key = '0;
  logic [31:0] rkey0, rkey1, rkey2, rkey3;
  logic [3:0] rnd;
  logic busy, ready;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {
    int cyc;
    logic [3:0] rnd;
    logic busy;
    logic ready;
    logic ck;
    logic [127:0] k;
  } exp_t;
  exp_t q[$];
  logic [127:0] rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_key_expand #(.NR(10)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .next(next), .rewind(rewind),
    .rkey0(rkey0), .rkey1(rkey1), .rkey2(rkey2), .rkey3(rkey3),
    .rnd(rnd), .busy(busy), .ready(ready));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("status{rnd,busy,ready}", 128'({rnd, busy, ready}), 128'({e.rnd, e.busy, e.ready}));
      if (e.ck) check("rkey", {rkey0, rkey1, rkey2, rkey3}, e.k);
    end
  end

  task automatic drive(input logic kl, input logic nx, input logic rw, input logic [127:0] k);
    @(negedge clk);
    kld = kl;
    next = nx;
    rewind = rw;
    key = k;
  endtask

  task automatic expect_o(input logic [3:0] r, input logic b, input logic rd, input logic ck, input logic [127:0] k);
    exp_t e;
    e.cyc = cyc + 1;
    e.rnd = r;
    e.busy = b;
    e.ready = rd;
    e.ck = ck;
    e.k = k;
    q.push_back(e);
  endtask

  task automatic async_rst();
    @(negedge clk);
    kld = 1'b0;
    next = 1'b0;
    rewind = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst_status", 128'({rnd, busy, ready}), 128'd0);
    check("async_rst_rkey", {rkey0, rkey1, rkey2, rkey3}, 128'd0);
    expect_o(0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    next = 1'b1;
    rewind = 1'b1;
    expect_o(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0);
    expect_o(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0);
    expect_o(0, 0, 0, 1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    expect_o(0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    next = 1'b1;
    rewind = 1'b1;
    expect_o(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0);
    expect_o(0, 0, 0, 1, 0);
    drive(1, 0, 0, rk[0]);
    expect_o(0, 1, 0, 1, rk[0]);
    for (int r = 1; r <= 10; r++) begin
      drive(0, r[0], r == 3, 0);
      expect_o(4'(r), r < 10, r == 10, 1, rk[r]);
    end
    drive(0, 0, 0, 0);
    expect_o(10, 0, 1, 1, rk[10]);
    for (int r = 9; r >= 0; r--) begin
      drive(0, 1, 0, 0);
      expect_o(4'(r), 0, 1, 1, rk[r]);
    end
    drive(0, 1, 0, 0);
    expect_o(0, 0, 1, 1, rk[0]);
    drive(0, 0, 1, 0);
    expect_o(10, 0, 1, 1, rk[10]);
    for (int r = 9; r >= 4; r--) begin
      drive(0, 1, 0, 0);
      expect_o(4'(r), 0, 1, 1, rk[r]);
    end
    drive(0, 1, 1, 0);
    expect_o(10, 0, 1, 1, rk[10]);
    drive(1, 1, 0, rk[0]);
    expect_o(0, 1, 0, 1, rk[0]);
    for (int r = 1; r <= 5; r++) begin
      drive(0, 0, 0, 0);
      expect_o(4'(r), 1, 0, 1, rk[r]);
    end
    drive(1, 0, 0, K2);
    expect_o(0, 1, 0, 1, K2);
    for (int r = 1; r <= 9; r++) begin
      drive(0, 0, 0, 0);
      expect_o(4'(r), 1, 0, 0, 0);
    end
    drive(0, 0, 0, 0);
    expect_o(10, 0, 1, 1, K2_R10);
    drive(1, 0, 0, rk[0]);
    expect_o(0, 1, 0, 1, rk[0]);
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 0);
      expect_o(4'(r), 1, 0, 1, rk[r]);
    end
    async_rst();
    drive(1, 0, 0, rk[0]);
    expect_o(0, 1, 0, 1, rk[0]);
    for (int r = 1; r <= 10; r++) begin
      drive(0, 0, 0, 0);
      expect_o(4'(r), r < 10, r == 10, 1, rk[r]);
    end
    drive(0, 1, 0, 0);
    expect_o(9, 0, 1, 1, rk[9]);
    async_rst();
    drive(0, 0, 0, 0);
    expect_o(0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
